// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// word width and the reset/NOP defaults used by the top and the PC register.
package instruction_fetch_stage_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_PC_RESET  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    localparam logic [INSTR_W-1:0] PC_STEP       = 32'd4;
    localparam logic [INSTR_W-1:0] PC_ALIGN_MASK = {{(INSTR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stage_pc_reg.sv
// Program counter register with +4 incrementer and redirect mux; redirect
// targets are forced to word alignment and wins over sequential advance.
module if_pc_reg
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] PC_RESET = DEFAULT_PC_RESET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_target,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4
);

    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target & PC_ALIGN_MASK;
        end else if (advance) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Natural 32-bit overflow gives the required wrap from 0xFFFF_FFFC to 0.
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + PC_STEP;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: request/response FSM towards instruction memory with
// stall hold buffer and branch redirect/drain. Optional performance counters
// are built when the macro IF_PERF_CNT_EN is defined.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] PC_RESET  = DEFAULT_PC_RESET,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               Branch_taken,
    input  logic [INSTR_W-1:0] Branch_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    output logic [INSTR_W-1:0] PCAdder_out,
    output logic [INSTR_W-1:0] Instruction_out,
    output logic               fetch_valid,
    output logic               IFID_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_adder_q, pc_adder_d;
    logic [INSTR_W-1:0] hold_buf_q, hold_buf_d;
    logic [INSTR_W-1:0] drain_addr_q, drain_addr_d;

    logic               pc_advance;
    logic               redirect;
    logic               deliver;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_plus4;

    if_pc_reg #(
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk             (Clk),
        .rst             (Rst),
        .advance         (pc_advance),
        .redirect        (redirect),
        .redirect_target (Branch_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4)
    );

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        instr_d       = instr_q;
        pc_adder_d    = pc_adder_q;
        hold_buf_d    = hold_buf_q;
        drain_addr_d  = drain_addr_q;
        redirect      = 1'b0;
        deliver       = 1'b0;
        pc_advance    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (Branch_taken) begin
                    redirect      = 1'b1;
                    fetch_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    hold_buf_d    = '0;
                    // Memory still owes us a response for the old PC; wait it out.
                    if (!imem_ready) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc;
                    end
                end else if (imem_ready && !Stall) begin
                    deliver = 1'b1;
                    instr_d = imem_rdata;
                end else if (imem_ready) begin
                    hold_buf_d = imem_rdata;
                    state_d    = HOLD;
                end else if (!Stall) begin
                    fetch_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                end
            end
            HOLD: begin
                if (Branch_taken) begin
                    redirect      = 1'b1;
                    fetch_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    hold_buf_d    = '0;
                    state_d       = REQ;
                end else if (!Stall) begin
                    deliver    = 1'b1;
                    instr_d    = hold_buf_q;
                    hold_buf_d = '0;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                fetch_valid_d = 1'b0;
                instr_d       = NOP_INSTR;
                redirect      = Branch_taken;
                if (imem_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (deliver) begin
            fetch_valid_d = 1'b1;
            pc_adder_d    = pc_plus4;
            pc_advance    = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_adder_q    <= '0;
            hold_buf_q    <= '0;
            drain_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
            pc_adder_q    <= pc_adder_d;
            hold_buf_q    <= hold_buf_d;
            drain_addr_q  <= drain_addr_d;
        end
    end

    // During DRAIN the PC already holds the target, so the in-flight address is kept aside.
    assign imem_req        = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr       = (state_q == DRAIN) ? drain_addr_q : pc;
    assign IFID_flush      = Branch_taken && (state_q != IDLE);
    assign fetch_valid     = fetch_valid_q;
    assign Instruction_out = instr_q;
    assign PCAdder_out     = pc_adder_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (deliver && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if ((state_q != IDLE) && !fetch_valid_q && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed scoreboard bench for instruction_fetch_stage: the stimulus thread
// queues hand-computed deliveries, a negedge monitor pops and compares them.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_target = '0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PCAdder_out;
    logic [31:0] Instruction_out;
    logic        fetch_valid;
    logic        IFID_flush;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_adder;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    logic stall_at_edge = 1'b0;

    instruction_fetch_stage #(
        .PC_RESET  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Stall           (Stall),
        .Branch_taken    (Branch_taken),
        .Branch_target   (Branch_target),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .PCAdder_out     (PCAdder_out),
        .Instruction_out (Instruction_out),
        .fetch_valid     (fetch_valid),
        .IFID_flush      (IFID_flush)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] tgt,
                                 input logic rdy, input logic [31:0] rdata);
        Stall         = stall;
        Branch_taken  = br;
        Branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = rdata;
    endtask

    task automatic expectDelivery(input logic [31:0] instr, input logic [31:0] pc_adder);
        exp_t e;
        e.instr    = instr;
        e.pc_adder = pc_adder;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkReq(input string name, input logic req, input logic [31:0] addr);
        checkOutput({name, "_req"}, 32'(imem_req), 32'(req));
        if (req) checkOutput({name, "_addr"}, imem_addr, addr);
    endtask

    // A held (stalled) output is not a new delivery, so only pop after a non-stall edge.
    always @(posedge Clk) stall_at_edge <= Stall;

    always @(negedge Clk) begin
        if (fetch_valid && !stall_at_edge) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_delivery: got instr 0x%08h pcadder 0x%08h expected no delivery",
                         Instruction_out, PCAdder_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("delivery_instr", Instruction_out, e.instr);
                checkOutput("delivery_pcadder", PCAdder_out, e.pc_adder);
            end
        end else if (!fetch_valid) begin
            checkOutput("bubble_nop", Instruction_out, NOP);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
        checkOutput("rst_instr", Instruction_out, NOP);
        checkOutput("rst_pcadder", PCAdder_out, 32'd0);
        checkOutput("rst_flush", 32'(IFID_flush), 32'd0);

        // Release reset with a stale response present: IDLE must ignore it.
        nextCycle();
        Rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'hBAD0_BAD0);
        @(negedge Clk);
        checkReq("idle", 1'b0, 32'd0);

        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1, 32'hA000_0000 | 32'(k));
            expectDelivery(32'hA000_0000 | 32'(k), 32'(4 * k + 4));
            @(negedge Clk);
            checkReq("stream", 1'b1, 32'(4 * k));
            if (k == 0) checkOutput("first_valid", 32'(fetch_valid), 32'd0);
        end

        // Response delayed three cycles at 0x10.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0);
            @(negedge Clk);
            checkReq("wait", 1'b1, 32'h10);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h0000_5555);
        expectDelivery(32'h0000_5555, 32'h14);
        @(negedge Clk);
        checkReq("wait_ready", 1'b1, 32'h10);

        // Data returns during a two-cycle stall and is parked in the hold buffer.
        nextCycle();
        applyStimulus(1, 0, 0, 1, 32'hDEAD_BEEF);
        @(negedge Clk);
        checkReq("stall_ready", 1'b1, 32'h14);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge Clk);
        checkReq("hold", 1'b0, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        expectDelivery(32'hDEAD_BEEF, 32'h18);
        @(negedge Clk);
        checkReq("hold_release", 1'b0, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge Clk);
        checkReq("after_hold", 1'b1, 32'h18);
        checkOutput("after_hold_valid", 32'(fetch_valid), 32'd1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge Clk);
        checkOutput("hold_once_valid", 32'(fetch_valid), 32'd0);
        checkReq("stall_inflight", 1'b1, 32'h18);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge Clk);
        checkReq("stall_inflight2", 1'b1, 32'h18);

        // Redirect to 0x103 while 0x18 is outstanding: drain then fetch 0x100.
        nextCycle();
        applyStimulus(0, 1, 32'h0000_0103, 0, 0);
        @(negedge Clk);
        checkOutput("br_flush", 32'(IFID_flush), 32'd1);
        checkReq("br_old", 1'b1, 32'h18);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge Clk);
        checkOutput("drain_flush", 32'(IFID_flush), 32'd0);
        checkReq("drain", 1'b1, 32'h18);
        checkOutput("drain_valid", 32'(fetch_valid), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'hBADD_A7A0);
        @(negedge Clk);
        checkReq("drain_ready", 1'b1, 32'h18);

        // Redirect coincident with a response: no drain, response dropped.
        nextCycle();
        applyStimulus(0, 1, 32'h0000_0040, 1, 32'hBADD_A7A1);
        @(negedge Clk);
        checkReq("target", 1'b1, 32'h100);
        checkOutput("coinc_flush", 32'(IFID_flush), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h0000_4444);
        expectDelivery(32'h0000_4444, 32'h44);
        @(negedge Clk);
        checkReq("coinc_target", 1'b1, 32'h40);
        checkOutput("coinc_valid", 32'(fetch_valid), 32'd0);

        // Wrap-around at the top of the address space; unaligned target is masked.
        nextCycle();
        applyStimulus(0, 1, 32'hFFFF_FFFF, 1, 32'hBADD_A7A2);
        @(negedge Clk);
        checkReq("wrap_br", 1'b1, 32'h44);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h7777_7777);
        expectDelivery(32'h7777_7777, 32'h0);
        @(negedge Clk);
        checkReq("wrap_top", 1'b1, 32'hFFFF_FFFC);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h8888_8888);
        expectDelivery(32'h8888_8888, 32'h4);
        @(negedge Clk);
        checkReq("wrap_zero", 1'b1, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge Clk);
        checkReq("pre_rst", 1'b1, 32'h4);
        checkOutput("pre_rst_pcadder", PCAdder_out, 32'h4);

        // Asynchronous reset in the middle of an outstanding request.
        #2;
        Branch_taken = 1'b1;
        Rst = 1'b1;
        #1;
        checkOutput("midrst_req", 32'(imem_req), 32'd0);
        checkOutput("midrst_valid", 32'(fetch_valid), 32'd0);
        checkOutput("midrst_instr", Instruction_out, NOP);
        checkOutput("midrst_pcadder", PCAdder_out, 32'd0);
        checkOutput("midrst_flush", 32'(IFID_flush), 32'd0);
        nextCycle();
        nextCycle();
        Rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'hBAD0_BAD1);
        @(negedge Clk);
        checkReq("idle2", 1'b0, 32'd0);

        // A second redirect during DRAIN only retargets.
        nextCycle();
        applyStimulus(0, 1, 32'h0000_0080, 0, 0);
        @(negedge Clk);
        checkReq("drain2_start", 1'b1, 32'h0);
        nextCycle();
        applyStimulus(0, 1, 32'h0000_0090, 0, 0);
        @(negedge Clk);
        checkReq("drain2_retarget", 1'b1, 32'h0);
        checkOutput("drain2_flush", 32'(IFID_flush), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'hBADD_A7A3);
        @(negedge Clk);
        checkReq("drain2_ready", 1'b1, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge Clk);
        checkReq("drain2_target", 1'b1, 32'h90);

        nextCycle();
        @(negedge Clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter PC_RESET, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, instruction word driven when no valid fetch.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 Stall  input  1  hazard-unit stall; hold PC and outputs.
REQ-006 Branch_taken  input  1  redirect request from later stage.
REQ-007 Branch_target  input  32  redirect PC; bits [1:0] forced to 0.
REQ-008 imem_rdata  input  32  instruction memory read data, valid with imem_ready.
REQ-009 imem_ready  input  1  memory response strobe.
REQ-010 imem_req  output  1  fetch request, held until imem_ready.
REQ-011 imem_addr  output  32  fetch address (current PC), stable while imem_req=1.
REQ-012 PCAdder_out  output  32  PC+4 of delivered instruction, to IF/ID register.
REQ-013 Instruction_out  output  32  delivered instruction, to IF/ID register.
REQ-014 fetch_valid  output  1  Instruction_out/PCAdder_out valid this cycle.
REQ-015 IFID_flush  output  1  one-cycle flush pulse to IF/ID register on redirect.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD, DRAIN; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-017 REQ: imem_req=1, imem_addr=PC; on imem_ready with Stall=0 -> Instruction_out=imem_rdata, PCAdder_out=PC+4, fetch_valid=1 next cycle, PC<=PC+4, stay REQ.
REQ-018 REQ with imem_ready=1 and Stall=1 SHALL capture imem_rdata into a hold buffer, deassert imem_req, go HOLD; outputs unchanged.
REQ-019 HOLD with Stall=0 SHALL deliver buffered word (fetch_valid=1), PC<=PC+4, return REQ; HOLD with Stall=1 SHALL remain HOLD.
REQ-020 Stall=1 with no response SHALL keep imem_req/imem_addr unchanged (request stays in flight).
REQ-021 Branch_taken SHALL have priority over Stall and imem_ready: PC<=Branch_target&~3, IFID_flush=1 for that cycle, fetch_valid=0 next cycle, hold buffer discarded.
REQ-022 Branch_taken in REQ with imem_ready=0 SHALL go DRAIN: imem_req/addr held at old PC until imem_ready, response discarded, then REQ at target.
REQ-023 Branch_taken coincident with imem_ready SHALL discard that response and go REQ at target next cycle (no DRAIN).
REQ-024 Branch_taken in DRAIN SHALL update target only; DRAIN continues.
REQ-025 When fetch_valid=0, Instruction_out SHALL be NOP_INSTR; PCAdder_out holds last value.
REQ-026 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-027 Outputs fetch_valid, Instruction_out, PCAdder_out SHALL be registered; imem_req/imem_addr decoded from state/PC only.

Reset
REQ-028 Rst=1 SHALL immediately set state IDLE, PC=PC_RESET, imem_req=0, fetch_valid=0, IFID_flush=0, Instruction_out=NOP_INSTR, PCAdder_out=0, hold buffer cleared.
REQ-029 Reset mid-request SHALL abandon the request; a late imem_ready after reset release while in IDLE SHALL be ignored.

Configuration
REQ-030 Macro IF_PERF_CNT_EN defined: outputs fetch_count[31:0] (delivered instructions) and bubble_count[31:0] (cycles with fetch_valid=0 after IDLE), saturating at 32'hFFFF_FFFF, reset to 0.
REQ-031 IF_PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, NOP_INSTR and PC_RESET defaults, and instruction width constant.
REQ-033 One sub-module if_pc_reg (PC register, +4 adder, redirect mux) SHALL be instantiated; FSM stays in top.

Verification
REQ-034 Reset release, imem_ready=1 every cycle -> imem_addr 0,4,8,...; fetch_valid from cycle 2; PCAdder_out 4,8,12.
REQ-035 imem_ready delayed 3 cycles at addr 0x10 -> imem_req/addr held 3 cycles; single delivery, PCAdder_out=0x14.
REQ-036 Stall=1 for 2 cycles as data 0xDEADBEEF returns -> HOLD, imem_req=0; after release Instruction_out=0xDEADBEEF once.
REQ-037 Branch_taken target 0x103 while request outstanding -> IFID_flush 1 cycle, DRAIN until ready, next imem_addr=0x100, old data never delivered.
REQ-038 PC=0xFFFF_FFFC fetch -> PCAdder_out=0, next imem_addr=0; Rst pulse mid-WAIT -> all outputs reset values same cycle.
